traffic_request_encoder: RTL
============================

TRAFFIC_REQUEST_ENCODER -- requirements
Module: traffic_request_encoder

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable cycles needed to accept a button level change (legal 1..15).
REQ-002 Parameter ACK_TIMEOUT, default 16: WAIT cycles allowed before a request is dropped (legal 1..255).
REQ-003 Parameter HOLD_CYCLES, default 2: cycles the request code is held after acknowledge (legal 1..15).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 res_n  input  1  reset, asynchronous, active-low.
REQ-006 btn  input  3  raw asynchronous request buttons; bit0 = phase s_0 (lights 1000), bit1 = s_1 (0100), bit2 = s_2 (0010).
REQ-007 lights  input  4  light word from the traffic controller, used as acknowledge.
REQ-008 req_code  output  2  request code to the controller `in` port; 2'b11 = no request (controller free-runs).
REQ-009 en  output  1  controller enable.
REQ-010 busy  output  1  high while a request is in flight (ISSUE/WAIT/HOLD).
REQ-011 err  output  1  one-cycle pulse on acknowledge timeout.
REQ-012 pend  output  3  pending-request flags, one per btn bit.

Function
REQ-013 Each btn bit SHALL pass a 2-flop synchronizer, then a per-bit debouncer: debounced level changes only after DEB_CYCLES consecutive cycles of synchronized value differing from it; any mismatch-free gap resets its counter.
REQ-014 Debounced rising edge of bit i SHALL set pend[i]; with btn[i] rising before edge 1 and held, pend[i] SHALL be high after edge DEB_CYCLES+3; re-press while pend[i]=1 SHALL have no effect.
REQ-015 FSM states: IDLE, ISSUE, WAIT, HOLD; registered outputs.
REQ-016 IDLE: req_code=2'b11, busy=0; when pend!=0 grant one bit by fixed priority bit0 > bit2 > bit1, go ISSUE; req_code SHALL show grant code (bit0->00, bit1->01, bit2->10) on that same edge.
REQ-017 ISSUE: lasts exactly one cycle, busy=1, code held, then WAIT with timer cleared.
REQ-018 WAIT: code held; when lights equals grant's one-hot word go HOLD; else timer increments each cycle.
REQ-019 WAIT timeout: on the ACK_TIMEOUT-th cycle without acknowledge, pulse err one cycle, clear pend[grant], go IDLE.
REQ-020 WAIT with lights==4'b1111 (controller disabled): abort to IDLE, pend unchanged, no err.
REQ-021 HOLD: code held HOLD_CYCLES cycles, then clear pend[grant], go IDLE; req_code=2'b11 on that edge.
REQ-022 Grant SHALL be latched in ISSUE; pend changes on other bits do not alter an in-flight request.
REQ-023 Same-cycle set and clear of the same pend bit: clear wins; set on a different bit in the same cycle takes effect.
REQ-024 en SHALL be 0 in reset and 1 from the first rising edge after res_n deasserts.

Reset
REQ-025 res_n low SHALL immediately force: state IDLE, req_code=2'b11, en=0, busy=0, err=0, pend=3'b000, synchronizers, debounced levels and all counters to 0.
REQ-026 Reset mid-request SHALL discard the request; no err pulse.

Verification
REQ-027 btn=001 held from edge 1, lights follow -> pend=001 after edge 7; req_code=00, busy=1 from edge 8; lights=1000 -> after 2 HOLD cycles req_code=11, pend=000.
REQ-028 btn=110 rising same cycle -> bit2 granted first (req_code=10), then bit1 (req_code=01) after first completes.
REQ-029 btn bit1 glitch high 3 cycles (DEB_CYCLES=4) -> pend stays 000, req_code stays 11.
REQ-030 Grant bit1, lights never 0100 -> err high exactly one cycle 16 cycles into WAIT, pend[1]=0, req_code=11.
REQ-031 lights=1111 during WAIT -> IDLE, pend retained, err=0; re-issue once lights leave 1111.
REQ-032 res_n low during HOLD -> req_code=11, en=0, pend=000 immediately, asynchronous to clk.

Source files
------------

// File: rtl/traffic_request_encoder.sv
// Turns debounced push-button requests into one-at-a-time request codes for the traffic
// controller, waiting for the matching light word as acknowledge.
module traffic_request_encoder #(
   parameter int unsigned DEB_CYCLES  = 4,
   parameter int unsigned ACK_TIMEOUT = 16,
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic       clk,
   input  logic       res_n,
   input  logic [2:0] btn,
   input  logic [3:0] lights,
   output logic [1:0] req_code,
   output logic       en,
   output logic       busy,
   output logic       err,
   output logic [2:0] pend
);

   localparam logic [3:0] DebMax   = 4'(DEB_CYCLES - 1);
   localparam logic [7:0] TimerMax = 8'(ACK_TIMEOUT - 1);
   localparam logic [3:0] HoldMax  = 4'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

   state_e          state_q, state_d;
   logic [2:0]      sync1_q, sync2_q;
   logic [2:0]      deb_q, deb_d, deb_prev_q;
   logic [2:0][3:0] deb_cnt_q, deb_cnt_d;
   logic [2:0]      pend_q, pend_d, clr;
   logic [1:0]      grant_q, grant_d;
   logic [7:0]      timer_q, timer_d;
   logic [3:0]      hold_q, hold_d;
   logic [1:0]      req_code_q, req_code_d;
   logic            busy_q, busy_d, err_q, err_d, en_q;
   logic [3:0]      ack_word;
   logic [1:0]      pick;

   // Level flips only after DebMax+1 consecutive mismatching samples.
   always_comb begin
      deb_d     = deb_q;
      deb_cnt_d = deb_cnt_q;
      for (int i = 0; i < 3; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (deb_cnt_q[i] == DebMax) begin
               deb_d[i]     = sync2_q[i];
               deb_cnt_d[i] = 4'd0;
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
            end
         end else begin
            deb_cnt_d[i] = 4'd0;
         end
      end
   end

   always_comb begin
      unique case (grant_q)
         2'd0:    ack_word = 4'b1000;
         2'd1:    ack_word = 4'b0100;
         default: ack_word = 4'b0010;
      endcase
   end

   // Fixed priority: bit0 > bit2 > bit1.
   assign pick = pend_q[0] ? 2'd0 : (pend_q[2] ? 2'd2 : 2'd1);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      timer_d = timer_q;
      hold_d  = hold_q;
      clr     = 3'b000;
      err_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pend_q != 3'b000 && lights != 4'b1111) begin
               grant_d = pick;
               state_d = StIssue;
            end
         end
         StIssue: begin
            timer_d = 8'd0;
            state_d = StWait;
         end
         StWait: begin
            if (lights == ack_word) begin
               hold_d  = 4'd0;
               state_d = StHold;
            end else if (lights == 4'b1111) begin
               state_d = StIdle;
            end else if (timer_q == TimerMax) begin
               err_d   = 1'b1;
               clr     = 3'b001 << grant_q;
               state_d = StIdle;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         StHold: begin
            if (hold_q == HoldMax) begin
               clr     = 3'b001 << grant_q;
               state_d = StIdle;
            end else begin
               hold_d = hold_q + 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
      // Clear wins over a simultaneous set on the same bit.
      pend_d     = (pend_q | (deb_q & ~deb_prev_q)) & ~clr;
      busy_d     = (state_d != StIdle);
      req_code_d = (state_d == StIdle) ? 2'b11 : grant_d;
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q    <= StIdle;
         sync1_q    <= 3'b000;
         sync2_q    <= 3'b000;
         deb_q      <= 3'b000;
         deb_prev_q <= 3'b000;
         deb_cnt_q  <= '0;
         pend_q     <= 3'b000;
         grant_q    <= 2'd0;
         timer_q    <= 8'd0;
         hold_q     <= 4'd0;
         req_code_q <= 2'b11;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         en_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync1_q    <= btn;
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         deb_cnt_q  <= deb_cnt_d;
         pend_q     <= pend_d;
         grant_q    <= grant_d;
         timer_q    <= timer_d;
         hold_q     <= hold_d;
         req_code_q <= req_code_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         en_q       <= 1'b1;
      end
   end

   assign req_code = req_code_q;
   assign busy     = busy_q;
   assign err      = err_q;
   assign pend     = pend_q;
   assign en       = en_q;

endmodule
